// File: rtl/niosiie_cmd_out.sv
`default_nettype none
// ============================================================================
// Module   : niosiie_cmd_out
// Purpose  : Avalon-MM slave command output port (CPU -> fabric direction of
//            the NIOS II PIO link). A CPU write loads a command word that is
//            presented to fabric logic with a valid/ready handshake. Busy state
//            and a saturating overrun counter are exposed for software polling.
// Ports    : clk, reset_n (async, active low)
//            address[1:0], chipselect, write_n, writedata[31:0] - Avalon slave
//            readdata[31:0]            - registered read data, 1-cycle latency
//            out_data[DATA_WIDTH-1:0]  - command word to fabric
//            out_valid / out_ready     - command handshake
// Params   : DATA_WIDTH (1..24), RESET_VALUE
// Macro    : CMD_OUT_SETCLR_EN - enables bit SET (addr 2) / CLR (addr 3)
//            registers; when undefined those addresses are inert, read 0.
// Revision : 1.0 - initial release
// ============================================================================
module niosiie_cmd_out #(
  parameter int                    DATA_WIDTH  = 24,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_PEND = 1'b1
  } state_t;

  localparam logic [7:0] c_CNT_MAX = 8'hFF;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_overrun;
  logic [7:0]            r_ovr_cnt;
  logic [31:0]           r_readdata;

  logic                  w_wr;
  logic                  w_data_wr;   // write that targets the data register
  logic [DATA_WIDTH-1:0] w_data_next;
  logic                  w_clr;
  logic                  w_ovr;
  logic [31:0]           w_data_ext;
  logic [31:0]           w_rd_mux;
  logic                  w_unused;

  assign w_wr       = chipselect & ~write_n;
  assign w_data_ext = {{(32-DATA_WIDTH){1'b0}}, r_data};
  assign w_clr      = w_wr && (address == 2'd1) && writedata[1];
  // Only a write that would overwrite an unaccepted word is an overrun; a
  // write in the same cycle as acceptance simply queues the next command.
  assign w_ovr      = (r_state == S_PEND) && !out_ready && w_data_wr;
  // Upper writedata bits are don't-care for narrow data widths.
  assign w_unused   = ^writedata;

  always_comb begin
    w_data_wr   = 1'b0;
    w_data_next = r_data;
    if (w_wr) begin
      case (address)
        2'd0: begin
          w_data_wr   = 1'b1;
          w_data_next = writedata[DATA_WIDTH-1:0];
        end
`ifdef CMD_OUT_SETCLR_EN
        2'd2: begin
          w_data_wr   = 1'b1;
          w_data_next = r_data | writedata[DATA_WIDTH-1:0];
        end
        2'd3: begin
          w_data_wr   = 1'b1;
          w_data_next = r_data & ~writedata[DATA_WIDTH-1:0];
        end
`endif
        default: begin
          w_data_wr   = 1'b0;
          w_data_next = r_data;
        end
      endcase
    end
  end

  always_comb begin
    w_rd_mux = '0;
    case (address)
      2'd0: w_rd_mux = w_data_ext;
      2'd1: w_rd_mux = {16'h0000, r_ovr_cnt, 6'b000000, r_overrun, (r_state == S_PEND)};
`ifdef CMD_OUT_SETCLR_EN
      2'd2: w_rd_mux = w_data_ext;
      2'd3: w_rd_mux = w_data_ext;
`endif
      default: w_rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_data     <= RESET_VALUE;
      r_overrun  <= 1'b0;
      r_ovr_cnt  <= 8'h00;
      r_readdata <= 32'h0;
    end else begin
      r_readdata <= w_rd_mux;

      if (r_state == S_IDLE) begin
        if (w_data_wr) begin
          r_data  <= w_data_next;
          r_state <= S_PEND;
        end
      end else begin
        // Discarded writes (no out_ready) leave r_data untouched.
        if (out_ready) begin
          if (w_data_wr) begin
            r_data <= w_data_next;
          end else begin
            r_state <= S_IDLE;
          end
        end
      end

      // An overrun coinciding with a software clear wins: the new event is
      // the first one counted after the clear.
      if (w_ovr) begin
        r_overrun <= 1'b1;
        if (w_clr) begin
          r_ovr_cnt <= 8'h01;
        end else if (r_ovr_cnt != c_CNT_MAX) begin
          r_ovr_cnt <= r_ovr_cnt + 8'h01;
        end
      end else if (w_clr) begin
        r_overrun <= 1'b0;
        r_ovr_cnt <= 8'h00;
      end
    end
  end

  assign out_data  = r_data;
  assign out_valid = (r_state == S_PEND);
  assign readdata  = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_niosiie_cmd_out.sv
`default_nettype none
// ============================================================================
// Module   : tb_niosiie_cmd_out
// Purpose  : Self-checking bench for niosiie_cmd_out (DATA_WIDTH=24,
//            RESET_VALUE=0). Table of per-cycle vectors plus hand-written
//            sequences for overrun saturation, async reset and SET/CLR.
// Revision : 1.0 - initial release
// ============================================================================
module tb_niosiie_cmd_out;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [23:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int tests_run;
  int tests_failed;

  niosiie_cmd_out #(
    .DATA_WIDTH (24),
    .RESET_VALUE(24'h000000)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .address   (address),
    .chipselect(chipselect),
    .write_n   (write_n),
    .writedata (writedata),
    .readdata  (readdata),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  addr;
    logic        cs;
    logic        wn;
    logic [31:0] wd;
    logic        rdy;
    logic        ev;   // expected out_valid after the edge
    logic [23:0] ed;   // expected out_data after the edge
    logic [31:0] er;   // expected readdata after the edge
  } vec_t;

  vec_t vecs[23];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] a, input logic cs, input logic wn,
                       input logic [31:0] wd, input logic rdy);
    address    = a;
    chipselect = cs;
    write_n    = wn;
    writedata  = wd;
    out_ready  = rdy;
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset_n      = 1'b0;
    drive(2'd0, 1'b0, 1'b1, 32'h0, 1'b0);

    //            addr  cs    wn    wdata          rdy   ev    ed          er
    vecs[0]  = '{2'd0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 24'h000000, 32'h00000000};
    vecs[1]  = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 24'h000000, 32'h00000000};
    vecs[2]  = '{2'd0, 1'b1, 1'b0, 32'h00ABCDEF,  1'b0, 1'b1, 24'hABCDEF, 32'h00000000};
    vecs[3]  = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 24'hABCDEF, 32'h00000001};
    vecs[4]  = '{2'd0, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 24'hABCDEF, 32'h00ABCDEF};
    vecs[5]  = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 24'hABCDEF, 32'h00000001};
    vecs[6]  = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b0, 24'hABCDEF, 32'h00000000};
    vecs[7]  = '{2'd0, 1'b1, 1'b0, 32'h00000456,  1'b0, 1'b1, 24'h000456, 32'h00ABCDEF};
    vecs[8]  = '{2'd0, 1'b1, 1'b0, 32'h00000123,  1'b0, 1'b1, 24'h000456, 32'h00000456};
    vecs[9]  = '{2'd0, 1'b1, 1'b0, 32'h00000123,  1'b0, 1'b1, 24'h000456, 32'h00000456};
    vecs[10] = '{2'd0, 1'b1, 1'b0, 32'h00000123,  1'b0, 1'b1, 24'h000456, 32'h00000456};
    vecs[11] = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 24'h000456, 32'h00000303};
    vecs[12] = '{2'd1, 1'b1, 1'b0, 32'h00000002,  1'b0, 1'b1, 24'h000456, 32'h00000303};
    vecs[13] = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 24'h000456, 32'h00000001};
    vecs[14] = '{2'd0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 24'h000456, 32'h00000456};
    vecs[15] = '{2'd0, 1'b1, 1'b0, 32'h00000011,  1'b0, 1'b1, 24'h000011, 32'h00000456};
    vecs[16] = '{2'd0, 1'b1, 1'b0, 32'h00000022,  1'b1, 1'b1, 24'h000022, 32'h00000011};
    vecs[17] = '{2'd1, 1'b0, 1'b1, 32'h0,         1'b0, 1'b1, 24'h000022, 32'h00000001};
    vecs[18] = '{2'd0, 1'b0, 1'b0, 32'h00000099,  1'b0, 1'b1, 24'h000022, 32'h00000022};
    vecs[19] = '{2'd0, 1'b1, 1'b1, 32'h00000077,  1'b0, 1'b1, 24'h000022, 32'h00000022};
    vecs[20] = '{2'd0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 24'h000022, 32'h00000022};
    vecs[21] = '{2'd0, 1'b1, 1'b0, 32'hFF123456,  1'b0, 1'b1, 24'h123456, 32'h00000022};
    vecs[22] = '{2'd0, 1'b0, 1'b1, 32'h0,         1'b1, 1'b0, 24'h123456, 32'h00123456};

    // Reset values while reset is asserted
    #2;
    check("rst_out_valid", {31'h0, out_valid}, 32'h0);
    check("rst_out_data",  {8'h0, out_data},   32'h0);
    check("rst_readdata",  readdata,           32'h0);
    tick();
    tick();
    reset_n = 1'b1;

    for (int i = 0; i < 23; i++) begin
      drive(vecs[i].addr, vecs[i].cs, vecs[i].wn, vecs[i].wd, vecs[i].rdy);
      tick();
      check($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vecs[i].ev});
      check($sformatf("vec%0d_data",  i), {8'h0, out_data},   {8'h0, vecs[i].ed});
      check($sformatf("vec%0d_rdata", i), readdata,           vecs[i].er);
    end

    // Overrun counter saturation
    drive(2'd0, 1'b1, 1'b0, 32'h0000005A, 1'b0);
    tick();
    for (int i = 0; i < 300; i++) begin
      drive(2'd0, 1'b1, 1'b0, 32'h00000123, 1'b0);
      tick();
    end
    drive(2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("sat_status", readdata, 32'h0000FF03);
    check("sat_data",   {8'h0, out_data}, 32'h0000005A);
    drive(2'd1, 1'b1, 1'b0, 32'h00000002, 1'b0);
    tick();
    drive(2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("clr_status", readdata, 32'h00000001);
    drive(2'd0, 1'b1, 1'b0, 32'h00000777, 1'b0);
    tick();
    drive(2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("restart_status", readdata, 32'h00000103);
    check("restart_data",   {8'h0, out_data}, 32'h0000005A);
    check("restart_valid",  {31'h0, out_valid}, 32'h1);

    // Asynchronous reset in the middle of a pending handshake
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_valid", {31'h0, out_valid}, 32'h0);
    check("async_rst_data",  {8'h0, out_data},   32'h0);
    check("async_rst_rdata", readdata,           32'h0);
    reset_n = 1'b1;
    drive(2'd0, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("post_rst_valid", {31'h0, out_valid}, 32'h0);

    // SET / CLR addresses
    drive(2'd0, 1'b1, 1'b0, 32'h000000F0, 1'b0);
    tick();
    drive(2'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    check("sc_base_valid", {31'h0, out_valid}, 32'h0);
    drive(2'd2, 1'b1, 1'b0, 32'h0000000F, 1'b0);
    tick();
`ifdef CMD_OUT_SETCLR_EN
    check("set_data",  {8'h0, out_data},   32'h000000FF);
    check("set_valid", {31'h0, out_valid}, 32'h1);
    drive(2'd0, 1'b0, 1'b1, 32'h0, 1'b1);
    tick();
    drive(2'd3, 1'b1, 1'b0, 32'h0000003C, 1'b0);
    tick();
    check("clr_data",  {8'h0, out_data},   32'h000000C3);
    check("clr_valid", {31'h0, out_valid}, 32'h1);
    drive(2'd2, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("rd_addr2", readdata, 32'h000000C3);
`else
    check("set_data",  {8'h0, out_data},   32'h000000F0);
    check("set_valid", {31'h0, out_valid}, 32'h0);
    drive(2'd3, 1'b1, 1'b0, 32'h0000003C, 1'b0);
    tick();
    check("clr_data",  {8'h0, out_data},   32'h000000F0);
    check("clr_valid", {31'h0, out_valid}, 32'h0);
    drive(2'd2, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("rd_addr2", readdata, 32'h00000000);
    drive(2'd1, 1'b0, 1'b1, 32'h0, 1'b0);
    tick();
    check("sc_status", readdata, 32'h00000000);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
